// File: rtl/sw_debounce_pkg.sv
// ---------------------------------------------------------------------------
// sw_debounce_pkg
// Shared definitions for the switch debounce bank.
//   - Default parameter values for the bank and its channels.
//   - ch_state_e: the implicit per-channel state (counter idle / counting).
//   - min_cnt_w(): smallest counter width that can hold DEBOUNCE-1. The top
//     level uses it for an elaboration-time width check.
// ---------------------------------------------------------------------------
package sw_debounce_pkg;

    localparam int DEF_N_CH        = 4;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_DEBOUNCE    = 16;
    localparam int DEF_CNT_W       = 8;

    // STABLE means the counter is idle (zero); any non-zero count is COUNTING.
    typedef enum logic {
        ST_STABLE   = 1'b0,
        ST_COUNTING = 1'b1
    } ch_state_e;

    // The counter must reach DEBOUNCE-1, so 2**w has to be at least DEBOUNCE.
    function automatic int min_cnt_w(input int debounce);
        int w;
        w = 1;
        while ((1 << w) < debounce) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/sw_debounce_ch.sv
// ---------------------------------------------------------------------------
// sw_debounce_ch
// One switch channel: synchroniser, optional inversion, stability counter,
// registered debounced level and one-cycle rise/fall pulses.
// Optional feature macro: SW_DEBOUNCE_TOGGLE_EN adds the push-on/push-off
// output tog_out.
//
// Ports:
//   clk        - system clock, rising edge
//   rst_n      - asynchronous active-low reset
//   en         - debounce enable; low clears the counter and holds the level
//   sw_in      - raw asynchronous switch level
//   inv_mask   - 1 inverts the synchronised level before debouncing
//   sw_out     - debounced level
//   rise_pulse - one cycle high when sw_out goes 0->1
//   fall_pulse - one cycle high when sw_out goes 1->0
//   busy       - counter is non-zero
//   tog_out    - (SW_DEBOUNCE_TOGGLE_EN only) flips on each rise_pulse
// ---------------------------------------------------------------------------
import sw_debounce_pkg::*;

module sw_debounce_ch #(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int DEBOUNCE    = DEF_DEBOUNCE,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic sw_in,
    input  logic inv_mask,
    output logic sw_out,
    output logic rise_pulse,
    output logic fall_pulse,
`ifdef SW_DEBOUNCE_TOGGLE_EN
    output logic tog_out,
`endif
    output logic busy
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   raw;
    ch_state_e              state;
`ifdef SW_DEBOUNCE_TOGGLE_EN
    logic                   tog_q, tog_d;
`endif

    // The synchroniser keeps shifting even while en is low, so re-enabling
    // always starts from a fresh sample of the pin.
    assign raw   = sync_q[SYNC_STAGES-1] ^ inv_mask;
    assign state = (cnt_q == '0) ? ST_STABLE : ST_COUNTING;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
`ifdef SW_DEBOUNCE_TOGGLE_EN
            tog_q   <= 1'b0;
`endif
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], sw_in};
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
`ifdef SW_DEBOUNCE_TOGGLE_EN
            tog_q   <= tog_d;
`endif
        end
    end

    // A level change commits only after DEBOUNCE consecutive disagreeing
    // cycles; any agreeing cycle in between drops the count back to zero, so
    // a bounce never produces a pulse. The counter is capped at DEBOUNCE-1.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
`ifdef SW_DEBOUNCE_TOGGLE_EN
        tog_d   = tog_q;
`endif
        if (!en) begin
            cnt_d = '0;
        end else begin
            case (state)
                ST_STABLE: begin
                    if (raw != level_q) begin
                        cnt_d = CNT_W'(1);
                    end
                end
                ST_COUNTING: begin
                    if (raw == level_q) begin
                        cnt_d = '0;
                    end else if (cnt_q == CNT_MAX) begin
                        cnt_d   = '0;
                        level_d = raw;
                        rise_d  = raw;
                        fall_d  = ~raw;
`ifdef SW_DEBOUNCE_TOGGLE_EN
                        tog_d   = tog_q ^ raw;
`endif
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: cnt_d = '0;
            endcase
        end
    end

    always_comb begin
        sw_out     = level_q;
        rise_pulse = rise_q;
        fall_pulse = fall_q;
        busy       = (state == ST_COUNTING);
`ifdef SW_DEBOUNCE_TOGGLE_EN
        tog_out    = tog_q;
`endif
    end

endmodule

// File: rtl/sw_debounce_bank.sv
// ---------------------------------------------------------------------------
// sw_debounce_bank
// N_CH independent debounced switch channels with optional inversion and
// rise/fall pulses. Optional feature macro: SW_DEBOUNCE_TOGGLE_EN adds the
// per-channel push-on/push-off output tog_out.
//
// Ports:
//   clk        - system clock, rising edge
//   rst_n      - asynchronous active-low reset
//   en         - debounce enable for all channels
//   sw_in      - raw asynchronous switch levels [N_CH]
//   inv_mask   - per-channel inversion, quasi-static [N_CH]
//   sw_out     - debounced levels [N_CH]
//   rise_pulse - one-cycle pulse per channel on sw_out 0->1 [N_CH]
//   fall_pulse - one-cycle pulse per channel on sw_out 1->0 [N_CH]
//   tog_out    - (SW_DEBOUNCE_TOGGLE_EN only) toggle latches [N_CH]
//   busy       - any channel counter non-zero
// ---------------------------------------------------------------------------
import sw_debounce_pkg::*;

module sw_debounce_bank #(
    parameter int N_CH        = DEF_N_CH,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int DEBOUNCE    = DEF_DEBOUNCE,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [N_CH-1:0] sw_in,
    input  logic [N_CH-1:0] inv_mask,
    output logic [N_CH-1:0] sw_out,
    output logic [N_CH-1:0] rise_pulse,
    output logic [N_CH-1:0] fall_pulse,
`ifdef SW_DEBOUNCE_TOGGLE_EN
    output logic [N_CH-1:0] tog_out,
`endif
    output logic            busy
);

    logic [N_CH-1:0] busy_ch;

    if (CNT_W < min_cnt_w(DEBOUNCE)) begin : g_bad_cnt_w
        $error("sw_debounce_bank: CNT_W too small to count to DEBOUNCE-1");
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        sw_debounce_ch #(
            .SYNC_STAGES(SYNC_STAGES),
            .DEBOUNCE   (DEBOUNCE),
            .CNT_W      (CNT_W)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .en        (en),
            .sw_in     (sw_in[i]),
            .inv_mask  (inv_mask[i]),
            .sw_out    (sw_out[i]),
            .rise_pulse(rise_pulse[i]),
            .fall_pulse(fall_pulse[i]),
`ifdef SW_DEBOUNCE_TOGGLE_EN
            .tog_out   (tog_out[i]),
`endif
            .busy      (busy_ch[i])
        );
    end

    // Derived straight from the counter registers, so no added latency.
    assign busy = |busy_ch;

endmodule
